bullet_engine: RTL and testbench

//  Frame-synchronous bullet motion/spawn engine sitting directly upstream of the space-shooter VGA peripheral.

---
 rtl/bullet_wr_if.sv | 11 +
 rtl/bullet_engine.sv | 162 ++++++++++++++++
 tb/tb_bullet_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_wr_if.sv
// Write bus from the bullet engine into the space-shooter display peripheral.
// The peripheral has no waitrequest, so a write is accepted in the cycle it is presented.
interface bullet_wr_if;
  logic       chipselect;
  logic       write;
  logic [4:0] address;
  logic [7:0] writedata;

  modport master (output chipselect, output write, output address, output writedata);
  modport slave  (input  chipselect, input  write, input  address, input  writedata);
endinterface

// File: rtl/bullet_engine.sv
// Per-frame bullet engine: on each VS falling edge it moves or spawns two bullets,
// then streams the ten bullet register bytes (offsets 11..20) to the display peripheral.
module bullet_engine #(
  parameter int unsigned SPEED       = 8,
  parameter int unsigned SHIP_WIDTH  = 40,
  parameter int unsigned SHIP_HEIGHT = 30,
  parameter int unsigned BULLET_SIZE = 4,
  parameter int unsigned HLIMIT      = 1280
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_vs,
  input  logic        fire1,
  input  logic        fire2,
  input  logic [10:0] ship1_x,
  input  logic [9:0]  ship1_y,
  input  logic [10:0] ship2_x,
  input  logic [9:0]  ship2_y,
  bullet_wr_if.master wr,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for the frame tick
  // UPDATE | one cycle: move/spawn both bullets
  // WRITE  | ten cycles: push bullet bytes to offsets 11..20
  typedef enum logic [1:0] {IDLE, UPDATE, WRITE} state_t;

  localparam logic [11:0] SPEED12 = 12'(SPEED);
  localparam logic [11:0] SHIPW12 = 12'(SHIP_WIDTH);
  localparam logic [11:0] HLIM12  = 12'(HLIMIT);
  localparam logic [10:0] SPEED11 = 11'(SPEED);
  localparam logic [10:0] BSIZE11 = 11'(BULLET_SIZE);
  localparam logic [9:0]  YOFF    = 10'((SHIP_HEIGHT - BULLET_SIZE) / 2);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        vs_dly_q;
  logic [10:0] b1x_q, b1x_d, b2x_q, b2x_d;
  logic [9:0]  b1y_q, b1y_d, b2y_q, b2y_d;
  logic        b1act_q, b1act_d, b2act_q, b2act_d;
  logic        pend1_q, pend1_d, pend2_q, pend2_d;
  logic        wr_q, wr_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        tick;
  logic [11:0] nx1, sx1;

  assign tick = vs_dly_q & ~vga_vs;
  assign nx1  = {1'b0, b1x_q} + SPEED12;
  assign sx1  = {1'b0, ship1_x} + SHIPW12;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    b1x_d   = b1x_q;
    b1y_d   = b1y_q;
    b1act_d = b1act_q;
    b2x_d   = b2x_q;
    b2y_d   = b2y_q;
    b2act_d = b2act_q;
    pend1_d = pend1_q | fire1;
    pend2_d = pend2_q | fire2;

    case (state_q)
      IDLE: begin
        if (tick) state_d = UPDATE;
      end
      UPDATE: begin
        // Pending requests are consumed here; a fire in this very cycle carries to next frame.
        pend1_d = fire1;
        pend2_d = fire2;
        state_d = WRITE;
        idx_d   = 4'd0;
        if (b1act_q) begin
          if (nx1 >= HLIM12) b1act_d = 1'b0;
          else               b1x_d   = nx1[10:0];
        end else if (pend1_q && (sx1 < HLIM12)) begin
          b1x_d   = sx1[10:0];
          b1y_d   = ship1_y + YOFF;
          b1act_d = 1'b1;
        end
        if (b2act_q) begin
          if (b2x_q < SPEED11) b2act_d = 1'b0;
          else                 b2x_d   = b2x_q - SPEED11;
        end else if (pend2_q && (ship2_x >= BSIZE11)) begin
          b2x_d   = ship2_x - BSIZE11;
          b2y_d   = ship2_y + YOFF;
          b2act_d = 1'b1;
        end
      end
      WRITE: begin
        if (idx_q == 4'd9) state_d = IDLE;
        else               idx_d   = idx_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the next state and next bullet values.
    wr_d   = (state_d == WRITE);
    addr_d = 5'd0;
    data_d = 8'd0;
    if (wr_d) begin
      addr_d = 5'd11 + {1'b0, idx_d};
      case (idx_d)
        4'd0:    data_d = b1x_d[7:0];
        4'd1:    data_d = {5'b0, b1x_d[10:8]};
        4'd2:    data_d = b1y_d[7:0];
        4'd3:    data_d = {6'b0, b1y_d[9:8]};
        4'd4:    data_d = {7'b0, b1act_d};
        4'd5:    data_d = b2x_d[7:0];
        4'd6:    data_d = {5'b0, b2x_d[10:8]};
        4'd7:    data_d = b2y_d[7:0];
        4'd8:    data_d = {6'b0, b2y_d[9:8]};
        4'd9:    data_d = {7'b0, b2act_d};
        default: data_d = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      vs_dly_q <= 1'b1;
      b1x_q    <= 11'd0;
      b1y_q    <= 10'd0;
      b1act_q  <= 1'b0;
      b2x_q    <= 11'd0;
      b2y_q    <= 10'd0;
      b2act_q  <= 1'b0;
      pend1_q  <= 1'b0;
      pend2_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vs_dly_q <= vga_vs;
      b1x_q    <= b1x_d;
      b1y_q    <= b1y_d;
      b1act_q  <= b1act_d;
      b2x_q    <= b2x_d;
      b2y_q    <= b2y_d;
      b2act_q  <= b2act_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign wr.chipselect = wr_q;
  assign wr.write      = wr_q;
  assign wr.address    = addr_q;
  assign wr.writedata  = data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bullet_engine.sv
// Scoreboard bench for bullet_engine: a frame-level bullet model predicts the ten register
// writes per frame; a monitor pops and compares every write the engine presents.
module tb_bullet_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vga_vs = 1'b1;
  logic        fire1 = 1'b0, fire2 = 1'b0;
  logic [10:0] ship1_x = '0, ship2_x = '0;
  logic [9:0]  ship1_y = '0, ship2_y = '0;
  logic        busy;

  bullet_wr_if wr ();

  bullet_engine dut (
    .clk(clk), .reset_n(reset_n), .vga_vs(vga_vs), .fire1(fire1), .fire2(fire2),
    .ship1_x(ship1_x), .ship1_y(ship1_y), .ship2_x(ship2_x), .ship2_y(ship2_y),
    .wr(wr), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  int n_busy = 0;
  logic [12:0] exp_q[$];

  // Reference model: bullet state as plain integers.
  int bx[2], by[2];
  bit ba[2], pend[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      bx[i] = 0; by[i] = 0; ba[i] = 0; pend[i] = 0;
    end
  endtask

  task automatic model_frame();
    int s;
    if (ba[0]) begin
      if (bx[0] + 8 >= 1280) ba[0] = 0;
      else bx[0] = bx[0] + 8;
    end else if (pend[0]) begin
      s = int'(ship1_x) + 40;
      if (s < 1280) begin
        bx[0] = s; by[0] = (int'(ship1_y) + 13) % 1024; ba[0] = 1;
      end
    end
    if (ba[1]) begin
      if (bx[1] < 8) ba[1] = 0;
      else bx[1] = bx[1] - 8;
    end else if (pend[1]) begin
      if (int'(ship2_x) >= 4) begin
        bx[1] = int'(ship2_x) - 4; by[1] = (int'(ship2_y) + 13) % 1024; ba[1] = 1;
      end
    end
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({5'(11 + 5*i), 8'(bx[i] % 256)});
      exp_q.push_back({5'(12 + 5*i), 8'(bx[i] / 256)});
      exp_q.push_back({5'(13 + 5*i), 8'(by[i] % 256)});
      exp_q.push_back({5'(14 + 5*i), 8'(by[i] / 256)});
      exp_q.push_back({5'(15 + 5*i), 8'(ba[i])});
    end
  endtask

  // Monitor: every presented write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) n_busy++;
      if (wr.write || wr.chipselect) begin
        logic [12:0] e;
        n_writes++;
        chk("cs_eq_write", 32'(wr.chipselect), 32'(wr.write));
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'({wr.address, wr.writedata}), 32'h0);
          if ({wr.address, wr.writedata} == 13'h0) begin
            errors++;
            $display("FAIL unexpected_write: got zero write with empty queue at %0t", $time);
          end
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr_data", 32'({wr.address, wr.writedata}), 32'(e));
        end
      end
    end
  end

  task automatic pulse_fire(input bit f1, input bit f2);
    @(posedge clk); #1;
    fire1 = f1; fire2 = f2;
    @(posedge clk); #1;
    fire1 = 1'b0; fire2 = 1'b0;
    if (f1) pend[0] = 1;
    if (f2) pend[1] = 1;
  endtask

  task automatic do_frame(input bit f1_upd, input bit f2_upd);
    int w0, b0;
    model_frame();
    w0 = n_writes; b0 = n_busy;
    @(posedge clk); #1 vga_vs = 1'b0;
    @(posedge clk); #1;
    fire1 = f1_upd; fire2 = f2_upd;
    @(negedge clk);
    chk("upd_busy", 32'(busy), 32'd1);
    chk("upd_no_write", 32'(wr.write), 32'd0);
    @(posedge clk); #1;
    fire1 = 1'b0; fire2 = 1'b0;
    if (f1_upd) pend[0] = 1;
    if (f2_upd) pend[1] = 1;
    @(negedge clk);
    chk("first_write_latency", 32'({wr.write, wr.address}), 32'({1'b1, 5'd11}));
    repeat (12) @(posedge clk);
    #1 vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("writes_per_frame", 32'(n_writes - w0), 32'd10);
    chk("busy_cycles", 32'(n_busy - b0), 32'd11);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_ships(input int x1, input int y1, input int x2, input int y2);
    @(posedge clk); #1;
    ship1_x = 11'(x1); ship1_y = 10'(y1); ship2_x = 11'(x2); ship2_y = 10'(y2);
  endtask

  task automatic reset_mid_write();
    bit seen;
    int w0;
    model_frame();
    seen = 0;
    @(posedge clk); #1 vga_vs = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr.write && wr.address == 5'd15) seen = 1;
    end
    chk("reached_5th_write", 32'(seen), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_write_drop", 32'({wr.write, wr.chipselect}), 32'd0);
    chk("rst_bus_zero", 32'({wr.address, wr.writedata}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    model_reset();
    vga_vs = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    w0 = n_writes;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("no_writes_after_reset", 32'(n_writes - w0), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", 32'({wr.chipselect, wr.write, wr.address, wr.writedata}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_no_busy", 32'(busy), 32'd0);

    // First-frame spawn from ship1, then one motion step.
    set_ships(200, 240, 0, 0);
    pulse_fire(1, 0);
    do_frame(0, 0);
    do_frame(0, 0);

    // Ship2 spawn and leftward motion; fire1 while b1 active is discarded.
    set_ships(200, 240, 1000, 240);
    pulse_fire(1, 1);
    do_frame(0, 0);
    do_frame(0, 0);

    reset_mid_write();

    // Right-edge death with position held; fire during dying frame is discarded.
    set_ships(1236, 500, 9, 1020);
    pulse_fire(1, 1);
    do_frame(0, 0);
    pulse_fire(1, 1);
    do_frame(0, 0);
    // Fire in the UPDATE cycle spawns on the following frame.
    do_frame(1, 1);
    do_frame(0, 0);
    do_frame(0, 0);

    // Spawn boundaries: no spawn at exactly HLIMIT / below BULLET_SIZE, spawn at x=0.
    set_ships(1240, 10, 3, 10);
    pulse_fire(1, 1);
    do_frame(0, 0);
    set_ships(1239, 1017, 4, 1015);
    pulse_fire(1, 1);
    do_frame(0, 0);
    do_frame(0, 0);

    for (int f = 0; f < 40; f++) begin
      int r;
      r = int'($urandom_range(0, 3));
      set_ships(int'($urandom_range(0, 1300)), int'($urandom_range(0, 1023)),
                (r == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 1300)),
                int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 1) == 1) pulse_fire(1'($urandom), 1'($urandom));
      do_frame($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
